// File: rtl/lcd_bus_arbiter_if.sv
// Requester and LCD-bus signal bundle for lcd_bus_arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/board side.
interface lcd_bus_arbiter_if;
   logic       req0;
   logic       rs0;
   logic [7:0] data0;
   logic       ack0;
   logic       req1;
   logic       rs1;
   logic [7:0] data1;
   logic       ack1;
   logic       busy;
   logic       init_done;
   logic [7:0] lcd_data;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_en;
   logic       lcd_on;

   modport master (
      output req0, rs0, data0, req1, rs1, data1,
      input  ack0, ack1, busy, init_done,
      input  lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on
   );

   modport slave (
      input  req0, rs0, data0, req1, rs1, data1,
      output ack0, ack1, busy, init_done,
      output lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on
   );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// HD44780 bus owner: optional power-on init (LCD_INIT_SEQ_EN), then round-robin byte writes from two requesters.
// Each write: SETUP -> PULSE -> WAIT, ack pulses one cycle after WAIT; requesters hold req until ack.
module lcd_bus_arbiter #(
   parameter int SETUP_CYCLES      = 2,
   parameter int EN_HIGH_CYCLES    = 12,
   parameter int CMD_WAIT_CYCLES   = 2000,
   parameter int CLEAR_WAIT_CYCLES = 82000,
   parameter int POWERUP_CYCLES    = 750000,
   parameter int CNT_W             = 20
) (
   input  logic             clock,
   input  logic             reset_n,
   lcd_bus_arbiter_if.slave bus
);

   typedef enum logic [2:0] {
      POWERUP,
      IDLE,
      SETUP,
      PULSE,
      WAIT
   } state_t;

   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);
   localparam logic [CNT_W-1:0] SETUP_LEN = CNT_W'(SETUP_CYCLES);
   localparam logic [CNT_W-1:0] EN_LEN    = CNT_W'(EN_HIGH_CYCLES);
   localparam logic [CNT_W-1:0] CMD_LEN   = CNT_W'(CMD_WAIT_CYCLES);
   localparam logic [CNT_W-1:0] CLR_LEN   = CNT_W'(CLEAR_WAIT_CYCLES);
   localparam logic [CNT_W-1:0] PWR_LEN   = CNT_W'(POWERUP_CYCLES);

`ifdef LCD_INIT_SEQ_EN
   localparam state_t RESET_STATE = POWERUP;
`else
   localparam state_t RESET_STATE = IDLE;
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             ld_q, ld_d;
   logic [7:0]       lcd_data_q, lcd_data_d;
   logic             lcd_rs_q, lcd_rs_d;
   logic             lcd_en_q, lcd_en_d;
   logic             lcd_on_q;
   logic             ack0_q, ack0_d;
   logic             ack1_q, ack1_d;
   logic             init_done_q, init_done_d;
   logic             last_grant_q, last_grant_d;
   logic             grant_q, grant_d;
   logic             in_init_q, in_init_d;
   logic [1:0]       init_idx_q, init_idx_d;

   logic [CNT_W-1:0] phase_len;
   logic [CNT_W-1:0] load_val;
   logic             expired;
   logic             is_clear;
   logic             pick1;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      logic [7:0] cmd;
      case (idx)
         2'd0:    cmd = 8'h38;
         2'd1:    cmd = 8'h0C;
         2'd2:    cmd = 8'h01;
         default: cmd = 8'h06;
      endcase
      return cmd;
   endfunction

   // Clear (0x01) and return-home (0x02/0x03) need the long settle time.
   assign is_clear = ~lcd_rs_q & (lcd_data_q[7:2] == 6'd0);

   always_comb begin
      phase_len = SETUP_LEN;
      case (state_q)
         POWERUP: phase_len = PWR_LEN;
         PULSE:   phase_len = EN_LEN;
         WAIT:    phase_len = is_clear ? CLR_LEN : CMD_LEN;
         default: phase_len = SETUP_LEN;
      endcase
   end

   // ld_q marks the first cycle of a phase: the timer is loaded then, so a
   // phase of N cycles ends on the N-th edge after it was entered.
   assign load_val = (phase_len > ONE) ? (phase_len - TWO) : '0;
   assign expired  = ld_q ? (phase_len == ONE) : (timer_q == '0);

   // Round-robin: on a tie the requester not served last wins.
   assign pick1 = bus.req1 & (~bus.req0 | ~last_grant_q);

   always_comb begin
      state_d      = state_q;
      lcd_data_d   = lcd_data_q;
      lcd_rs_d     = lcd_rs_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      in_init_d    = in_init_q;
      init_idx_d   = init_idx_q;
`ifdef LCD_INIT_SEQ_EN
      init_done_d  = init_done_q;
`else
      init_done_d  = 1'b1;
`endif

      if (ld_q) begin
         timer_d = load_val;
      end else if (timer_q != '0) begin
         timer_d = timer_q - ONE;
      end else begin
         timer_d = timer_q;
      end

      case (state_q)
         POWERUP: begin
            if (expired) begin
               in_init_d  = 1'b1;
               init_idx_d = 2'd0;
               lcd_data_d = init_cmd(2'd0);
               lcd_rs_d   = 1'b0;
               state_d    = SETUP;
            end
         end
         IDLE: begin
            if (bus.req0 | bus.req1) begin
               grant_d    = pick1;
               lcd_rs_d   = pick1 ? bus.rs1 : bus.rs0;
               lcd_data_d = pick1 ? bus.data1 : bus.data0;
               state_d    = SETUP;
            end
         end
         SETUP: begin
            if (expired) state_d = PULSE;
         end
         PULSE: begin
            if (expired) state_d = WAIT;
         end
         WAIT: begin
            if (expired) begin
               if (in_init_q) begin
                  if (init_idx_q == 2'd3) begin
                     in_init_d   = 1'b0;
                     init_done_d = 1'b1;
                     state_d     = IDLE;
                  end else begin
                     init_idx_d = init_idx_q + 2'd1;
                     lcd_data_d = init_cmd(init_idx_q + 2'd1);
                     lcd_rs_d   = 1'b0;
                     state_d    = SETUP;
                  end
               end else begin
                  ack0_d       = ~grant_q;
                  ack1_d       = grant_q;
                  last_grant_d = grant_q;
                  state_d      = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      ld_d     = (state_d != state_q);
      lcd_en_d = (state_d == PULSE);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q      <= RESET_STATE;
         timer_q      <= '0;
         ld_q         <= 1'b1;
         lcd_data_q   <= 8'h00;
         lcd_rs_q     <= 1'b0;
         lcd_en_q     <= 1'b0;
         lcd_on_q     <= 1'b1;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         init_done_q  <= 1'b0;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         in_init_q    <= 1'b0;
         init_idx_q   <= 2'd0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         ld_q         <= ld_d;
         lcd_data_q   <= lcd_data_d;
         lcd_rs_q     <= lcd_rs_d;
         lcd_en_q     <= lcd_en_d;
         lcd_on_q     <= 1'b1;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         init_done_q  <= init_done_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         in_init_q    <= in_init_d;
         init_idx_q   <= init_idx_d;
      end
   end

   assign bus.ack0      = ack0_q;
   assign bus.ack1      = ack1_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.init_done = init_done_q;
   assign bus.lcd_data  = lcd_data_q;
   assign bus.lcd_rs    = lcd_rs_q;
   assign bus.lcd_rw    = 1'b0;
   assign bus.lcd_en    = lcd_en_q;
   assign bus.lcd_on    = lcd_on_q;

endmodule
